uart_rx_os: RTL and testbench

Second-generation UART receiver with 16x (parametrisable) oversampling and 3-sample majority voting. Adds a runtime baud divisor, optional even/odd parity, and 1 or 2 stop bits. Reports per-frame error flags and break detection. Received frames go into a small first-word-fall-through FIFO with a valid/ready output handshake. Sits between the pad-side uart_rxd line and the bus-side peripheral register block.

---
 rtl/uart_rx_os.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority voting, parity/stop options,
// break detection and a first-word-fall-through receive FIFO.
module uart_rx_os #(
    parameter int PAYLOAD_BITS = 8,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              uart_rxd,
    input  logic                              uart_rx_en,
    input  logic [DIV_WIDTH-1:0]              cfg_div,
    input  logic                              cfg_parity_en,
    input  logic                              cfg_parity_odd,
    input  logic                              cfg_stop2,
    output logic [PAYLOAD_BITS-1:0]           rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic                              rx_frame_err,
    output logic                              rx_parity_err,
    output logic                              rx_break,
    output logic                              rx_overrun,
    input  logic                              rx_overrun_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level
);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(PAYLOAD_BITS);
    localparam int EW = PAYLOAD_BITS + 3;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OW-1:0] OS_A  = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] OS_B  = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] OS_C  = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [OW-1:0] OS_L  = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_L = BW'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sync_q, smp_q, smp_d;
    logic [DIV_WIDTH-1:0]    tcnt_q, tcnt_d, div_q, div_d;
    logic [OW-1:0]           os_q, os_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic                    pen_q, pen_d, podd_q, podd_d, stop2_q, stop2_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    par_q, par_d, ferr_q, ferr_d, push_q, push_d;
    logic [EW-1:0]           ent_q, ent_d;
    logic                    rxd_s, tick, maj, decide, last, fe, brk, perr;

    assign rxd_s  = sync_q[1];
    assign tick   = uart_rx_en && tcnt_q == (state_q == IDLE ? cfg_div : div_q);
    assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s) | (smp_q[1] & rxd_s);
    assign decide = tick && os_q == OS_C;
    assign last   = tick && os_q == OS_L;
    assign fe     = ferr_q | ~maj;
    assign brk    = data_q == '0 && !(pen_q && par_q) && fe;
    assign perr   = pen_q & ((^data_q ^ par_q) != podd_q);

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        os_d    = os_q;
        bit_d   = bit_q;
        div_d   = div_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        stop2_d = stop2_q;
        smp_d   = smp_q;
        data_d  = data_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        push_d  = 1'b0;
        ent_d   = ent_q;
        if (uart_rx_en) begin
            tcnt_d = tick ? '0 : tcnt_q + 1'b1;
            if (tick && state_q != IDLE) os_d = last ? '0 : os_q + 1'b1;
            if (tick && os_q == OS_A) smp_d[0] = rxd_s;
            if (tick && os_q == OS_B) smp_d[1] = rxd_s;
            case (state_q)
                IDLE: if (!rxd_s) begin
                    state_d = START;
                    tcnt_d  = '0;
                    os_d    = '0;
                    bit_d   = '0;
                    div_d   = cfg_div;
                    pen_d   = cfg_parity_en;
                    podd_d  = cfg_parity_odd;
                    stop2_d = cfg_stop2;
                    par_d   = 1'b0;
                    ferr_d  = 1'b0;
                end
                START: state_d = (decide && maj) ? IDLE : last ? DATA : START;
                DATA: begin
                    if (decide) data_d = {maj, data_q[PAYLOAD_BITS-1:1]};
                    if (last) begin
                        bit_d = bit_q == BIT_L ? '0 : bit_q + 1'b1;
                        if (bit_q == BIT_L) state_d = pen_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (decide) par_d = maj;
                    if (last) state_d = STOP;
                end
                // The last stop bit completes the frame at its decision tick.
                STOP: if (decide) begin
                    ferr_d = fe;
                    if (bit_q == BW'(stop2_q)) begin
                        push_d  = 1'b1;
                        ent_d   = {brk, perr, fe, data_q};
                        state_d = brk ? BRK_WAIT : IDLE;
                    end
                end else if (last) begin
                    bit_d = bit_q + 1'b1;
                end
                BRK_WAIT: if (rxd_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = IDLE;
            tcnt_d  = '0;
            os_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            tcnt_q  <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            stop2_q <= 1'b0;
            smp_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            push_q  <= 1'b0;
            ent_q   <= '0;
        end else begin
            if (uart_rx_en) sync_q <= {sync_q[0], uart_rxd};
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            stop2_q <= stop2_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            push_q  <= push_d;
            ent_q   <= ent_d;
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q;
    logic          ovr_q, pop, full, wr;

    assign pop      = rx_valid && rx_ready;
    assign full     = level_q == LW'(FIFO_DEPTH);
    assign wr       = push_q && (!full || pop);
    assign rx_valid = level_q != '0;
    assign rx_level = level_q;
    assign rx_overrun = ovr_q;
    assign head     = rx_valid ? mem_q[rd_q] : '0;
    assign {rx_break, rx_parity_err, rx_frame_err, rx_data} = head;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            wr_q    <= wr_q + PW'(wr);
            rd_q    <= rd_q + PW'(pop);
            level_q <= level_q + LW'(wr) - LW'(pop);
            ovr_q   <= (push_q && full && !pop) ? 1'b1 : rx_overrun_clr ? 1'b0 : ovr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= ent_q;
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed and randomized frames checked against a frame-level reference model.
module tb_uart_rx_os;
    logic        clk = 1'b0, resetn = 1'b0, uart_rxd = 1'b1, uart_rx_en = 1'b1;
    logic [15:0] cfg_div = 16'd3;
    logic        cfg_parity_en = 1'b0, cfg_parity_odd = 1'b0, cfg_stop2 = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready = 1'b1, rx_frame_err, rx_parity_err, rx_break, rx_overrun;
    logic        rx_overrun_clr = 1'b0;
    logic [2:0]  rx_level;
    int          checks = 0, errors = 0, cyc = 0, stop_cyc = 0, rise_cyc = 0, run = 0, maxrun = 0;
    logic        pv = 1'b0;
    logic [10:0] got[$], exp_q[$];

    uart_rx_os dut (
        .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
        .cfg_div(cfg_div), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2(cfg_stop2), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_break(rx_break),
        .rx_overrun(rx_overrun), .rx_overrun_clr(rx_overrun_clr), .rx_level(rx_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (resetn && rx_valid && rx_ready) got.push_back({rx_break, rx_parity_err, rx_frame_err, rx_data});
        if (rx_valid && !pv) rise_cyc = cyc;
        if (rx_valid) run++;
        else begin
            if (run > maxrun) maxrun = run;
            run = 0;
        end
        pv = rx_valid;
    end

    function automatic logic [10:0] model(input logic [7:0] d, input logic pen, input logic odd,
                                          input logic pbit, input logic ferr);
        logic perr = pen && ((^d ^ pbit) != odd);
        logic brk  = d == 8'h00 && (!pen || !pbit) && ferr;
        return {brk, perr, ferr, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, ex);
        end
    endtask

    task automatic drive(input logic v, input int n);
        @(negedge clk);
        uart_rxd = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] d, input logic pbit);
        int   b   = 16 * (int'(cfg_div) + 1);
        logic pen = cfg_parity_en;
        logic odd = cfg_parity_odd;
        int   ns  = cfg_stop2 ? 2 : 1;
        exp_q.push_back(model(d, pen, odd, pbit, 1'b0));
        drive(1'b0, b);
        for (int i = 0; i < 8; i++) drive(d[i], b);
        if (pen) drive(pbit, b);
        stop_cyc = cyc;
        for (int i = 0; i < ns; i++) drive(1'b1, b);
    endtask

    task automatic compare(input string tag);
        repeat (8) @(negedge clk);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        while (got.size() > 0 && exp_q.size() > 0) chk(tag, 32'(got.pop_front()), 32'(exp_q.pop_front()));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_level", 32'(rx_level), 0);
        chk("rst_overrun", 32'(rx_overrun), 0);
        chk("rst_head", 32'({rx_break, rx_parity_err, rx_frame_err, rx_data}), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        maxrun = 0;
        frame(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        chk("a5_pulse", 32'(maxrun), 1);
        chk("a5_latency", 32'(rise_cyc > stop_cyc && rise_cyc - stop_cyc <= 139), 1);
        compare("a5");

        for (int n = 0; n < 10; n++) begin
            cfg_div        = 16'($urandom_range(1, 3));
            cfg_parity_en  = 1'($urandom);
            cfg_parity_odd = 1'($urandom);
            cfg_stop2      = 1'($urandom);
            d = 8'($urandom);
            frame(d, (^d ^ cfg_parity_odd) ^ ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        compare("random");

        cfg_div = 16'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        fork
            frame(8'hC3, 1'b0);
            begin
                repeat (100) @(negedge clk);
                cfg_div = 16'd0; cfg_parity_en = 1'b1; cfg_stop2 = 1'b1;
            end
        join
        compare("cfg_latch");

        cfg_div = 16'd3; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
        frame(8'h3C, 1'b0);
        frame(8'h3C, 1'b1);
        compare("parity");

        cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        @(negedge clk) uart_rxd = 1'b0;
        repeat (8) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (192) @(negedge clk);
        chk("glitch_none", 32'(got.size()), 0);
        chk("glitch_level", 32'(rx_level), 0);
        frame(8'h55, 1'b0);
        compare("glitch_next");

        @(negedge clk) uart_rxd = 1'b0;
        exp_q.push_back(model(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (20 * 64) @(negedge clk);
        compare("break");
        uart_rxd = 1'b1;
        repeat (128) @(negedge clk);
        chk("break_quiet", 32'(got.size()), 0);
        frame(8'h5A, 1'b0);
        compare("after_break");

        rx_ready = 1'b0;
        cfg_div = 16'd1;
        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0);
        void'(exp_q.pop_back());
        repeat (10) @(negedge clk);
        chk("ovr_level", 32'(rx_level), 4);
        chk("ovr_flag", 32'(rx_overrun), 1);
        chk("ovr_head", 32'(rx_data), 1);
        rx_ready = 1'b1;
        compare("ovr_drain");
        chk("ovr_sticky", 32'(rx_overrun), 1);
        rx_overrun_clr = 1'b1;
        @(negedge clk) rx_overrun_clr = 1'b0;
        chk("ovr_clr", 32'(rx_overrun), 0);

        rx_ready = 1'b0;
        frame(8'h11, 1'b0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        chk("pre_rst_level", 32'(rx_level), 1);
        fork
            frame(8'h81, 1'b0);
            begin
                repeat (32 * 4 + 16) @(negedge clk);
                resetn = 1'b0;
                #1;
                chk("mid_rst_valid", 32'(rx_valid), 0);
                chk("mid_rst_level", 32'(rx_level), 0);
                chk("mid_rst_data", 32'(rx_data), 0);
            end
        join
        exp_q.delete();
        got.delete();
        @(negedge clk) resetn = 1'b1;
        rx_ready = 1'b1;
        repeat (20) @(negedge clk);
        frame(8'h81, 1'b0);
        compare("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
